// File: rtl/rv32i_decode.sv
// RV32I decode stage: handshaked fetch in, registered decoded packet out.
// Register-file read addresses are driven combinationally on accept.
module rv32i_decode #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 6
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_instr,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_flush,
  output logic [RADDR_W-1:0] o_rs_addr_1,
  output logic [RADDR_W-1:0] o_rs_addr_2,
  output logic               o_renable,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_pc,
  output logic [RADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]    o_imm,
  output logic [2:0]         o_funct3,
  output logic [3:0]         o_alu_op,
  output logic [2:0]         o_class,
  output logic               o_wb_en,
  output logic               o_illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_FEN = 7'b0001111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  localparam int PAD = RADDR_W - 5;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       f7_ok;

  assign op    = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign rd    = i_instr[11:7];
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20);

  logic accept;

  assign o_ready   = !i_flush && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready;
  assign o_renable = accept;

  logic              use1, use2;
  logic signed [31:0] imm32;
  logic [3:0]        alu_d;
  logic [2:0]        cls_d;
  logic              wb_d, ill_d;

  always_comb begin
    use1  = 1'b0;
    use2  = 1'b0;
    imm32 = '0;
    alu_d = 4'b0000;
    cls_d = 3'd0;
    wb_d  = 1'b0;
    ill_d = 1'b0;
    case (op)
      OP_R: begin
        use1  = 1'b1;
        use2  = 1'b1;
        alu_d = {f7[5], f3};
        wb_d  = 1'b1;
        ill_d = !f7_ok ||
                (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
      end
      OP_I: begin
        use1  = 1'b1;
        imm32 = 32'(signed'(i_instr[31:20]));
        alu_d = {1'b0, f3};
        wb_d  = 1'b1;
        if (f3 == 3'b001) ill_d = (f7 != 7'h00);
        if (f3 == 3'b101) begin
          ill_d = !f7_ok;
          alu_d = {f7[5], f3};
        end
      end
      OP_FEN: cls_d = 3'd0;
      OP_LD: begin
        use1  = 1'b1;
        imm32 = 32'(signed'(i_instr[31:20]));
        cls_d = 3'd1;
        wb_d  = 1'b1;
        ill_d = (f3 == 3'b011) || (f3 == 3'b110) ||
                (f3 == 3'b111);
      end
      OP_ST: begin
        use1  = 1'b1;
        use2  = 1'b1;
        imm32 = 32'(signed'({i_instr[31:25], i_instr[11:7]}));
        cls_d = 3'd2;
        ill_d = (f3 >= 3'b011);
      end
      OP_BR: begin
        use1  = 1'b1;
        use2  = 1'b1;
        imm32 = 32'(signed'({i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8],
                             1'b0}));
        cls_d = 3'd3;
        ill_d = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JAL: begin
        imm32 = 32'(signed'({i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21],
                             1'b0}));
        cls_d = 3'd4;
        wb_d  = 1'b1;
      end
      OP_JLR: begin
        use1  = 1'b1;
        imm32 = 32'(signed'(i_instr[31:20]));
        cls_d = 3'd5;
        wb_d  = 1'b1;
        ill_d = (f3 != 3'b000);
      end
      OP_LUI, OP_AUI: begin
        imm32 = {i_instr[31:12], 12'b0};
        cls_d = (op == OP_LUI) ? 3'd6 : 3'd7;
        wb_d  = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    // Illegal packets go out as a harmless ALU no-op
    if (ill_d) begin
      cls_d = 3'd0;
      alu_d = 4'b0000;
      wb_d  = 1'b0;
    end
    if (rd == 5'd0) wb_d = 1'b0;
  end

  assign o_rs_addr_1 = use1 ? {{PAD{1'b0}}, i_instr[19:15]} : '0;
  assign o_rs_addr_2 = use2 ? {{PAD{1'b0}}, i_instr[24:20]} : '0;

  logic               valid_d;
  logic [RADDR_W-1:0] rd_d;

  assign rd_d = wb_d ? {{PAD{1'b0}}, rd} : '0;

  always_comb begin
    valid_d = o_valid;
    if (i_flush)                 valid_d = 1'b0;
    else if (accept)             valid_d = 1'b1;
    else if (o_valid && i_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_pc      <= '0;
      o_rd_addr <= '0;
      o_imm     <= '0;
      o_funct3  <= '0;
      o_alu_op  <= '0;
      o_class   <= '0;
      o_wb_en   <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      o_valid <= valid_d;
      if (accept) begin
        o_pc      <= i_pc;
        o_rd_addr <= rd_d;
        o_imm     <= XLEN'(imm32);
        o_funct3  <= f3;
        o_alu_op  <= alu_d;
        o_class   <= cls_d;
        o_wb_en   <= wb_d;
        o_illegal <= ill_d;
      end
    end
  end

endmodule

// File: doc/rv32i_decode.md
Name: rv32i_decode

Overview:
- Single-entry pipelined RV32I decode stage, directly upstream of the base register file.
- Accepts fetched instruction/PC over a valid/ready handshake.
- Drives register-file read addresses and read enable on the accept edge, so operand data is ready when the decoded packet is presented.
- Presents the registered decoded packet (rd, immediate, ALU op, class, write-back enable, illegal flag) to execute over a valid/ready handshake; supports flush.

Parameters:
- XLEN, 32, datapath/PC/immediate width.
- RADDR_W, 6, register address port width; upper bit always driven 0.

Ports:
- clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_instr  input  32  instruction word from fetch
- i_pc  input  XLEN  PC of i_instr
- i_valid  input  1  fetch has instruction
- o_ready  output  1  decode can accept this cycle
- i_flush  input  1  kill held packet and any incoming instruction
- o_rs_addr_1  output  RADDR_W  register file read address 1 (combinational)
- o_rs_addr_2  output  RADDR_W  register file read address 2 (combinational)
- o_renable  output  1  register file read enable (combinational, equals accept)
- o_valid  output  1  decoded packet valid
- i_ready  input  1  execute accepts packet
- o_pc  output  XLEN  registered PC
- o_rd_addr  output  RADDR_W  destination register
- o_imm  output  XLEN  sign-extended immediate
- o_funct3  output  3  raw funct3 (branch/load/store width)
- o_alu_op  output  4  ALU op
- o_class  output  3  instruction class
- o_wb_en  output  1  writes rd
- o_illegal  output  1  undecodable instruction

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_pc=0, o_rd_addr=0, o_imm=0, o_funct3=0, o_alu_op=0, o_class=0, o_wb_en=0, o_illegal=0.
- Handshake:
  - o_ready = !i_flush && (!o_valid || i_ready).
  - accept = i_valid && o_ready.
- Latency: one cycle from accept to o_valid.
- Register update:
  - On accept, all packet registers load and o_valid<=1.
  - Else if o_valid && i_ready, o_valid<=0.
  - Else hold.
- Stall (o_valid && !i_ready): packet stable; o_renable=0 so register file read addresses hold.
- Flush: i_flush=1 forces o_valid<=0 next edge and blocks accept (flush has priority over everything except reset). Packet data registers may hold stale values.
- o_rs_addr_1 = {0, i_instr[19:15]} for OP, OP-IMM, LOAD, STORE, BRANCH, JALR; else 0.
- o_rs_addr_2 = {0, i_instr[24:20]} for OP, STORE, BRANCH; else 0.
- o_renable = accept.
- Instruction classes (o_class):
  - 0 ALU: opcodes 0110011, 0010011, and FENCE 0001111.
  - 1 LOAD 0000011, 2 STORE 0100011, 3 BRANCH 1100011.
  - 4 JAL 1101111, 5 JALR 1100111, 6 LUI 0110111, 7 AUIPC 0010111.
- Immediates:
  - I-type for OP-IMM/LOAD/JALR; S for STORE; B for BRANCH (bit0=0); U for LUI/AUIPC (low 12 bits zero); J for JAL (bit0=0).
  - All sign-extended from instr[31].
  - OP and FENCE: imm=0.
- o_alu_op encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - OP: {funct7[5], funct3}.
  - OP-IMM: {0, funct3}, except SRAI which gives 1101.
  - All other classes: ADD.
- o_wb_en: 1 for ALU (except FENCE), LOAD, JAL, JALR, LUI, AUIPC, and only when rd≠0. 0 for STORE, BRANCH, FENCE, illegal.
- o_rd_addr = {0, instr[11:7]}; forced to 0 when o_wb_en=0.
- o_illegal=1 for any of:
  - instr[1:0]≠11 or unlisted opcode (incl. SYSTEM);
  - OP with funct7 ∉ {0x00, 0x20}, or 0x20 with funct3 ∉ {000, 101};
  - SLLI with funct7≠0; SRLI/SRAI with funct7 ∉ {0x00, 0x20};
  - LOAD funct3 ∈ {011, 110, 111}; STORE funct3 ≥ 011; BRANCH funct3 ∈ {010, 011}; JALR funct3≠0.
- Illegal packet: class=0, alu_op=0, wb_en=0, still presented with o_valid=1.

Test Plan:
- Reset asserted mid-stall with o_valid=1 -> all outputs 0 immediately (async); after release, o_ready=1.
- i_instr=0xFFF08293 (addi x5,x1,-1), i_pc=0x100, i_ready=1 -> same cycle: o_rs_addr_1=1, o_rs_addr_2=0, o_renable=1. Next cycle: o_valid=1, o_rd_addr=5, o_imm=0xFFFFFFFF, o_class=0, o_alu_op=0000, o_wb_en=1, o_pc=0x100.
- i_instr=0x402081B3 (sub x3,x1,x2) then 0xFE208EE3 (beq x1,x2,-4), back-to-back -> first packet: alu_op=1000, rd=3. Second packet: class=3, imm=0xFFFFFFFC, funct3=000, wb_en=0, rd=0, rs1=1, rs2=2.
- Stall: packet valid, i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0, o_renable=0, outputs stable. i_ready=1 -> next instruction accepted same cycle.
- Flush with o_valid=1 and i_valid=1 -> o_ready=0 that cycle, o_valid=0 next cycle, incoming instruction dropped.
- i_instr=0x00000000 and 0x00000073 (ecall) -> o_valid=1, o_illegal=1, o_wb_en=0; 0x00001013 (slli x0,x0,0) -> illegal=0, wb_en=0 (rd=0).
